// File: rtl/mdu_if.sv
// Multiply/divide unit request/result bundle: the core drives the request side
// (master); the MDU returns busy/done and the architectural HI/LO registers (slave).
interface mdu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
    modport slave  (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit: one shift-add / restoring-subtract per cycle.
// The divider datapath (DIV/DIVU) is built only when MDU_DIV_EN is defined.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef MDU_DIV_EN
    logic           is_div_q, is_div_d;
    logic           rneg_q, rneg_d;
    logic           dbz_q, dbz_d;
    logic [W:0]     rsh;
    logic [W-1:0]   rdiff;
    logic           ge;
    logic [2*W-1:0] div_next;
`endif

    logic           signed_op, rs_neg, rt_neg, go_mul, go_div;
    logic [W-1:0]   rs_mag, rt_mag;
    logic [W:0]     msum;
    logic [2*W-1:0] mul_next, step_next, prod_fix;

    always_comb begin
        signed_op = ~bus.op[0];
        rs_neg    = signed_op & bus.rs_data[W-1];
        rt_neg    = signed_op & bus.rt_data[W-1];
        rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
        rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;
        go_mul    = bus.start && (bus.op == 3'd0 || bus.op == 3'd1);
`ifdef MDU_DIV_EN
        go_div    = bus.start && (bus.op == 3'd2 || bus.op == 3'd3);
`else
        go_div    = 1'b0;
`endif

        // acc = {partial product, remaining multiplier bits}; shifts right each step
        msum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, {W{acc_q[0]}} & b_q};
        mul_next  = {msum, acc_q[W-1:1]};
`ifdef MDU_DIV_EN
        // acc = {partial remainder, dividend bits being shifted out / quotient shifted in}
        rsh       = {acc_q[2*W-1:W], acc_q[W-1]};
        ge        = rsh >= {1'b0, b_q};
        rdiff     = rsh[W-1:0] - b_q;
        div_next  = {ge ? rdiff : rsh[W-1:0], acc_q[W-2:0], ge};
        step_next = is_div_q ? div_next : mul_next;
`else
        step_next = mul_next;
`endif
        prod_fix  = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MDU_DIV_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (go_mul || go_div) begin
                    state_d  = RUN;
                    cnt_d    = 6'd0;
                    busy_d   = 1'b1;
                    neg_d    = rs_neg ^ rt_neg;
                    acc_d    = {{W{1'b0}}, go_div ? rs_mag : rt_mag};
                    b_d      = go_div ? rt_mag : rs_mag;
`ifdef MDU_DIV_EN
                    is_div_d = go_div;
                    rneg_d   = rs_neg;
                    dbz_d    = (bus.rt_data == '0);
`endif
                end else if (bus.start && bus.op == 3'd4) begin
                    hi_d = bus.rs_data;
                end else if (bus.start && bus.op == 3'd5) begin
                    lo_d = bus.rs_data;
                end
            end
            RUN: begin
                acc_d = step_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(W-1)) state_d = FIX;
            end
            FIX: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
                // divide by zero leaves quotient all-ones; remainder already equals rs
                if (is_div_q) begin
                    lo_d = dbz_q ? '1 : (neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
                    hi_d = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Randomized + directed bench for mdu against an arithmetic reference model.
module tb_mdu;
    logic clk = 1'b0;
    logic rst;

    mdu_if #(.WIDTH(32)) bus();
    mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected {hi,lo} straight from the instruction semantics.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return res;
    endfunction

    // Transaction-level model: an accepted op resolves 33 cycles later.
    int          m_cyc  = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_res  = '0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cyc > 0) begin
                m_cyc--;
                if (m_cyc == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end else if (bus.start) begin
                if (bus.op <= 3'd1 || (DIV_EN && bus.op <= 3'd3)) begin
                    m_res = ref_res(bus.op, bus.rs_data, bus.rt_data);
                    m_cyc = 33;
                end else if (bus.op == 3'd4) m_hi = bus.rs_data;
                else if (bus.op == 3'd5) m_lo = bus.rs_data;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("busy", 64'(bus.busy), 64'(m_cyc > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("hi", 64'(bus.hi), 64'(m_hi));
            chk("lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
    endtask

    task automatic run_lit(input string nm, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        issue(o, a, b);
        wait_done(n);
        chk({nm, "_latency"}, 64'(n), 64'd33);
        chk({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(elo));
        @(negedge clk);
        chk({nm, "_done_width"}, 64'(bus.done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        run_lit("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_lit("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
`ifdef MDU_DIV_EN
        run_lit("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_lit("divu_by0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_lit("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
`endif

        // MTHI / MTLO take effect on the accepting edge with no busy or done
        issue(3'd4, 32'hA5A5_0001, 32'd0);
        chk("mthi_hi", 64'(bus.hi), 64'hA5A5_0001);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_done", 64'(bus.done), 64'd0);
        issue(3'd5, 32'h5A5A_0002, 32'd0);
        chk("mtlo_lo", 64'(bus.lo), 64'h5A5A_0002);

        // reserved op leaves everything alone
        issue(3'd6, 32'h1, 32'h2);
        chk("rsvd_busy", 64'(bus.busy), 64'd0);
        chk("rsvd_hi", 64'(bus.hi), 64'hA5A5_0001);

`ifndef MDU_DIV_EN
        issue(3'd2, 32'd8, 32'd2);
        chk("nodiv_busy", 64'(bus.busy), 64'd0);
        count_done(40, seen);
        chk("nodiv_done", 64'(seen), 64'd0);
        chk("nodiv_hi", 64'(bus.hi), 64'hA5A5_0001);
        chk("nodiv_lo", 64'(bus.lo), 64'h5A5A_0002);
`endif

        // MTHI while busy must be dropped
        #1; rst = 1'b1; #2; rst = 1'b0;
        issue(3'd1, 32'd5, 32'd6);
        issue(3'd4, 32'h1234, 32'd0);
        wait_done(n);
        chk("busy_mthi_hi", 64'(bus.hi), 64'd0);
        chk("busy_mthi_lo", 64'(bus.lo), 64'd30);

        // reset ten cycles into RUN aborts the op
        issue(3'd1, 32'hFFFF, 32'hFFFF);
        repeat (9) @(negedge clk);
        #2; rst = 1'b1; #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        #1; rst = 1'b0;
        count_done(45, seen);
        chk("abort_no_done", 64'(seen), 64'd0);

        // random traffic, including requests during busy and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if ($urandom % 400 == 0) begin
                rst = 1'b1; #2; rst = 1'b0;
            end
            bus.start   = ($urandom % 3 == 0);
            bus.op      = 3'($urandom % 8);
            bus.rs_data = pick();
            bus.rt_data = pick();
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; the block is specified and verified at 32.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request, sampled on clk rising edge.
REQ-005 SHALL have port op  input  3  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved.
REQ-006 SHALL have port rs_data  input  WIDTH  first operand (dividend, multiplicand, or MTHI/MTLO source), driven from register-file read port 1.
REQ-007 SHALL have port rt_data  input  WIDTH  second operand (divisor, multiplier), driven from register-file read port 2.
REQ-008 SHALL have port busy  output  1  high while an operation is in flight; the core stalls on busy.
REQ-009 SHALL have port done  output  1  one-cycle pulse when new HI/LO results become visible.
REQ-010 SHALL have port hi  output  WIDTH  HI register; feeds the register-file write data path for MFHI.
REQ-011 SHALL have port lo  output  WIDTH  LO register; feeds the register-file write data path for MFLO.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FIX; busy SHALL be 1 exactly in RUN and FIX.
REQ-013 SHALL, in IDLE with start=1 and op in 0..3, latch operand magnitudes and signedness, clear the 6-bit iteration counter, and enter RUN.
REQ-014 SHALL stay in RUN for exactly 32 cycles, performing one shift-add (MULT/MULTU) or one restoring shift-subtract (DIV/DIVU) step per cycle, then enter FIX.
REQ-015 SHALL, in FIX, apply the sign correction, write hi/lo, pulse done for exactly one cycle, and return to IDLE.
REQ-016 SHALL make results visible 33 cycles after the accepting edge; done SHALL be 1 in the cycle immediately after busy falls.
REQ-017 SHALL produce {hi,lo} as the full 64-bit product: two's-complement for MULT, unsigned for MULTU.
REQ-018 SHALL truncate the DIV quotient toward zero into lo and give the remainder the sign of the dividend in hi; DIVU SHALL be unsigned.
REQ-019 SHALL, on divide by zero (rt_data=0), set hi=rs_data and lo=0xFFFFFFFF after the normal 33-cycle latency.
REQ-020 SHALL return lo=0x80000000 and hi=0 for DIV of 0x80000000 by 0xFFFFFFFF.
REQ-021 SHALL, in IDLE with start=1 and op=4 (or op=5), write rs_data into hi (or lo) on that edge, keep busy=0, and not pulse done.
REQ-022 SHALL ignore start while busy=1, including MTHI/MTLO; operands of the in-flight operation SHALL be unaffected.
REQ-023 SHALL ignore reserved op codes 6 and 7 with no state change.
REQ-024 SHALL hold hi and lo stable during RUN and FIX, and change them only in FIX or on MTHI/MTLO.

Reset
REQ-025 SHALL, on rst=1, immediately force the state to IDLE, counter=0, busy=0, done=0, hi=0 and lo=0, independent of clk.
REQ-026 SHALL, if reset occurs mid-operation, abort the operation, discard its result, and never pulse done for it.

Configuration
REQ-027 SHALL compile the divider datapath only when macro MDU_DIV_EN is defined; when MDU_DIV_EN is undefined, op 2 and op 3 SHALL be treated as reserved (no busy, hi/lo unchanged, no done pulse), and multiply and MTHI/MTLO behaviour SHALL be unchanged.

Verification
REQ-028 SHALL cover: MULT with rs=0xFFFFFFFE, rt=3 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done high for 1 cycle.
REQ-029 SHALL cover: MULTU with 0xFFFFFFFF by 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 SHALL cover: DIV of 0xFFFFFFF9 (-7) by 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU of 7 by 0 -> hi=7, lo=0xFFFFFFFF; DIV of 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL cover: MULTU 5 by 6 followed by start=1 with op=4, rs=0x1234 during busy -> request ignored, final hi=0, lo=30.
REQ-032 SHALL cover: rst pulsed at RUN cycle 10 of MULTU -> busy=0 and hi=lo=0 immediately, and no done pulse afterwards.
REQ-033 SHALL cover: build without MDU_DIV_EN, DIV 8 by 2 issued -> busy stays 0 and hi/lo keep their prior values.
